// File: rtl/tx_arbiter_if.sv
// rtl/tx_arbiter_if.sv - requester and transmitter signal bundle for tx_arbiter
interface tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic              link_up;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [IDW-1:0]    tx_owner;
  logic              tx_done;
  logic              tx_abort;

  // arbiter view
  modport master (
    input  link_up, req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_start, tx_owner, tx_done, tx_abort
  );

  // requester / transmitter view
  modport slave (
    output link_up, req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_start, tx_owner, tx_done, tx_abort
  );
endinterface

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin byte arbiter for one UART transmitter (optional TX_TAG_EN owner tag byte)
module tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  tx_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
`ifdef TX_TAG_EN
    S_TAG       = 3'd1,
`endif
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           start_q, start_d;
  logic           done_q, done_d;
  logic           abort_q, abort_d;
`ifdef TX_TAG_EN
  logic           tag_phase_q, tag_phase_d;
  logic [7:0]     tag_byte;
`endif

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan_idx;
  logic [7:0]     grant_byte;
  logic           accept;
  logic [NREQ-1:0] ready;

  // round-robin search starting just past the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign grant_byte = 8'(bus.req_data >> {grant_idx, 3'b000});
  assign accept     = (state_q == S_IDLE) && bus.link_up && grant_found;

  // only an idle arbiter with the link up offers a one-hot ready
  always_comb begin
    ready = '0;
    if (accept) ready = NREQ'(1) << grant_idx;
  end

`ifdef TX_TAG_EN
  assign tag_byte = 8'hA0 | 8'(owner_q);
`endif

  // next-state and pulse outputs; link loss overrides every other event
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    tx_data_d    = tx_data_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    start_d      = 1'b0;
    done_d       = 1'b0;
    abort_d      = 1'b0;
`ifdef TX_TAG_EN
    tag_phase_d  = tag_phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d       = grant_byte;
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
`ifdef TX_TAG_EN
          state_d      = S_TAG;
`else
          state_d      = S_START;
`endif
        end
      end
`ifdef TX_TAG_EN
      S_TAG: begin
        if (!bus.link_up) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tx_data_d   = tag_byte;
          start_d     = 1'b1;
          cnt_d       = '0;
          tag_phase_d = 1'b1;
          state_d     = S_WAIT_BUSY;
        end
      end
`endif
      S_START: begin
        if (!bus.link_up) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tx_data_d   = data_q;
          start_d     = 1'b1;
          cnt_d       = '0;
`ifdef TX_TAG_EN
          tag_phase_d = 1'b0;
`endif
          state_d     = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!bus.link_up) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.link_up) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (!bus.tx_busy) begin
`ifdef TX_TAG_EN
          if (tag_phase_q) begin
            state_d = S_START;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`else
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers; rst returns all outputs to idle values
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_q       <= 8'h00;
      tx_data_q    <= 8'h00;
      owner_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      cnt_q        <= 8'h00;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
`ifdef TX_TAG_EN
      tag_phase_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      tx_data_q    <= tx_data_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
`ifdef TX_TAG_EN
      tag_phase_q  <= tag_phase_d;
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = start_q;
  assign bus.tx_owner  = owner_q;
  assign bus.tx_done   = done_q;
  assign bus.tx_abort  = abort_q;

endmodule
